rx_huge_page_ctrl: RTL and testbench
====================================

Name: rx_huge_page_ctrl

Overview:
Sequences host huge pages for the RX path on the clk156 side. Host-posted 2 MB page base addresses are queued and presented one at a time as the current write target. The controller services the rx trigger's change_huge_page request, issues a close record (page base, payload QW count) to the TLP engine, then advances to the next queued page. It is the owner of change_huge_page_ack and of the current-page address seen by the TLP datapath.

Parameters:
DEPTH, 4, number of queued page descriptors (power of 2, >=2)
PTR_W, $clog2(DEPTH), descriptor FIFO pointer width

Ports:
clk156  in  1  clock, 156.25 MHz domain
reset_n  in  1  asynchronous active-low reset
hp_wr_en  in  1  host posts one page descriptor this cycle
hp_wr_addr  in  64  page base address, 2 MB aligned
hp_fifo_full  out  1  descriptor queue holds DEPTH entries
hp_pending  out  PTR_W+1  queued descriptors, excluding the current page
hp_overflow  out  1  sticky: a post was dropped because the queue was full
hp_misaligned  out  1  sticky: a post was dropped because hp_wr_addr[20:0] != 0
current_hp_valid  out  1  current_hp_addr is a live target
current_hp_addr  out  64  base of the page being filled
change_huge_page  in  1  level request from the rx trigger
change_huge_page_ack  out  1  four-phase ack
hp_qword_count  in  19  QWs written to the current page, including the 16-QW header
close_req  out  1  request to write the header of the closed page
close_addr  out  64  base of the page being closed
close_qwords  out  19  payload QWs = hp_qword_count - 16
close_ack  in  1  single-cycle ack from the TLP engine
pages_closed  out  32  wrapping count of completed closes

Behaviour:
- Reset values: all outputs 0; FIFO empty; FSM in NOPAGE. Reset mid-operation aborts any close. Queued descriptors are lost, and the host must re-post them.
- Post filter, in priority order: misaligned -> drop and set hp_misaligned; else full -> drop and set hp_overflow, unless a pop occurs in the same cycle, in which case the post is accepted; else enqueue. Sticky flags clear only on reset.
- A simultaneous push and pop leaves the count unchanged. Pointers wrap modulo DEPTH.
- FSM states:
  - NOPAGE: current_hp_valid=0. If the FIFO is non-empty, pop into current_hp_addr, go to ACTIVE, and set current_hp_valid=1 on the next cycle. Pop-to-valid latency is 1 cycle.
  - ACTIVE: current_hp_valid=1. On change_huge_page=1, latch close_addr=current_hp_addr and close_qwords=hp_qword_count-16, set current_hp_valid=0 and close_req=1, go to CLOSE.
    - If hp_qword_count < 16, close_qwords saturates to 0.
    - If hp_qword_count == 16 (page empty), the close is still issued with close_qwords=0.
  - CLOSE: hold close_req and the close fields stable until close_ack. On ack: close_req=0, increment pages_closed, set change_huge_page_ack=1, go to ACK. A close_ack seen outside CLOSE is ignored.
  - ACK: hold the ack until change_huge_page=0, then drop the ack. If the FIFO is non-empty, pop and go to ACTIVE; else go to NOPAGE.
- change_huge_page received in NOPAGE is not acked until a page is loaded and closed. The requester stalls; no close is issued for a nonexistent page.
- hp_pending excludes the current page. hp_fifo_full = (count == DEPTH).

Decomposition:
- Shared package: HP_ADDR_W=64, HP_QW_W=19, HP_RESERVED_QW=16, HP_ALIGN_BITS=21, and the FSM state encodings, consistent with the trigger's 19-bit QW counter.
- One sub-module: hp_desc_fifo, a synchronous DEPTH x 64 FIFO with push, pop, full, empty and count outputs. Same clock; async active-low reset.

Test Plan:
- Reset, then post 0x0000_0001_0020_0000 -> one cycle after the pop: current_hp_valid=1, current_hp_addr matches, hp_pending=0.
- Post 0x...0010_0100 (misaligned) -> hp_misaligned=1, hp_pending unchanged, no page loaded.
- With 2 pages queued and the first active, assert change_huge_page with hp_qword_count=0x110 -> close_req with close_addr=page0, close_qwords=0x100. On close_ack: ack=1, pages_closed=1. After the request drops: page1 is current and hp_pending=0.
- DEPTH=4 with a full queue: a 5th post -> hp_overflow=1, dropped. Then a full post in the same cycle as a pop (ACK exit) -> accepted, count stays 4.
- Request change with an empty queue -> close completes, then NOPAGE with current_hp_valid=0. A later post -> ACTIVE with the new address.
- Assert reset_n low while in CLOSE -> all outputs 0 immediately, FSM in NOPAGE, pages_closed=0.

Source files
------------

// File: rtl/rx_huge_page_ctrl_pkg.sv
// Shared widths, FSM encoding and close-length helper for the RX huge-page controller.
package rx_huge_page_ctrl_pkg;

    localparam int HP_ADDR_W      = 64;
    localparam int HP_QW_W        = 19;
    localparam int HP_RESERVED_QW = 16;
    localparam int HP_ALIGN_BITS  = 21;

    typedef enum logic [1:0] {
        ST_NOPAGE = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_CLOSE  = 2'd2,
        ST_ACK    = 2'd3
    } hp_state_e;

    // Payload length excludes the 16-QW header; a short page clamps to zero.
    function automatic logic [HP_QW_W-1:0] payload_qw(input logic [HP_QW_W-1:0] qw);
        return (qw > HP_QW_W'(HP_RESERVED_QW)) ? qw - HP_QW_W'(HP_RESERVED_QW) : '0;
    endfunction

endpackage

// File: rtl/rx_huge_page_ctrl_desc_fifo.sv
// Page descriptor queue; a push on a full queue lands only when a pop frees a slot that cycle.
module hp_desc_fifo
    import rx_huge_page_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                 clk156,
    input  logic                 reset_n,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic [HP_ADDR_W-1:0] data_i,
    output logic [HP_ADDR_W-1:0] data_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [PTR_W:0]       count_o
);

    logic [HP_ADDR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]       count_q;
    logic                 do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk156 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk156) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/rx_huge_page_ctrl.sv
// Holds the current RX huge page, closes it on the trigger's request and advances to the next queued page.
module rx_huge_page_ctrl
    import rx_huge_page_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                 clk156,
    input  logic                 reset_n,
    input  logic                 hp_wr_en,
    input  logic [HP_ADDR_W-1:0] hp_wr_addr,
    output logic                 hp_fifo_full,
    output logic [PTR_W:0]       hp_pending,
    output logic                 hp_overflow,
    output logic                 hp_misaligned,
    output logic                 current_hp_valid,
    output logic [HP_ADDR_W-1:0] current_hp_addr,
    input  logic                 change_huge_page,
    output logic                 change_huge_page_ack,
    input  logic [HP_QW_W-1:0]   hp_qword_count,
    output logic                 close_req,
    output logic [HP_ADDR_W-1:0] close_addr,
    output logic [HP_QW_W-1:0]   close_qwords,
    input  logic                 close_ack,
    output logic [31:0]          pages_closed
);

    hp_state_e            state_q, state_d;
    logic [HP_ADDR_W-1:0] cur_addr_q, cur_addr_d, close_addr_q, close_addr_d;
    logic [HP_QW_W-1:0]   close_qw_q, close_qw_d;
    logic [31:0]          closed_q, closed_d;
    logic                 valid_q, valid_d, creq_q, creq_d, ack_q, ack_d;
    logic                 ovf_q, mis_q;
    logic                 aligned, pop, fifo_full, fifo_empty;
    logic [HP_ADDR_W-1:0] fifo_head;

    assign aligned = (hp_wr_addr[HP_ALIGN_BITS-1:0] == '0);

    hp_desc_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
        .clk156  (clk156),
        .reset_n (reset_n),
        .push_i  (hp_wr_en & aligned),
        .pop_i   (pop),
        .data_i  (hp_wr_addr),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (hp_pending)
    );

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        close_addr_d = close_addr_q;
        close_qw_d   = close_qw_q;
        closed_d     = closed_q;
        valid_d      = valid_q;
        creq_d       = creq_q;
        ack_d        = ack_q;
        pop          = 1'b0;
        case (state_q)
            ST_NOPAGE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    cur_addr_d = fifo_head;
                    valid_d    = 1'b1;
                    state_d    = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (change_huge_page) begin
                    close_addr_d = cur_addr_q;
                    close_qw_d   = payload_qw(hp_qword_count);
                    valid_d      = 1'b0;
                    creq_d       = 1'b1;
                    state_d      = ST_CLOSE;
                end
            end
            ST_CLOSE: begin
                if (close_ack) begin
                    creq_d   = 1'b0;
                    closed_d = closed_q + 32'd1;
                    ack_d    = 1'b1;
                    state_d  = ST_ACK;
                end
            end
            ST_ACK: begin
                // Next page is loaded in the same cycle the handshake completes.
                if (!change_huge_page) begin
                    ack_d = 1'b0;
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        cur_addr_d = fifo_head;
                        valid_d    = 1'b1;
                        state_d    = ST_ACTIVE;
                    end else begin
                        state_d = ST_NOPAGE;
                    end
                end
            end
            default: state_d = ST_NOPAGE;
        endcase
    end

    always_ff @(posedge clk156 or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_NOPAGE;
            cur_addr_q   <= '0;
            close_addr_q <= '0;
            close_qw_q   <= '0;
            closed_q     <= '0;
            valid_q      <= 1'b0;
            creq_q       <= 1'b0;
            ack_q        <= 1'b0;
            ovf_q        <= 1'b0;
            mis_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            close_addr_q <= close_addr_d;
            close_qw_q   <= close_qw_d;
            closed_q     <= closed_d;
            valid_q      <= valid_d;
            creq_q       <= creq_d;
            ack_q        <= ack_d;
            if (hp_wr_en && !aligned)                    mis_q <= 1'b1;
            if (hp_wr_en && aligned && fifo_full && !pop) ovf_q <= 1'b1;
        end
    end

    assign hp_fifo_full         = fifo_full;
    assign hp_overflow          = ovf_q;
    assign hp_misaligned        = mis_q;
    assign current_hp_valid     = valid_q;
    assign current_hp_addr      = cur_addr_q;
    assign change_huge_page_ack = ack_q;
    assign close_req            = creq_q;
    assign close_addr           = close_addr_q;
    assign close_qwords         = close_qw_q;
    assign pages_closed         = closed_q;

endmodule

// File: tb/tb_rx_huge_page_ctrl.sv
// Self-checking bench: directed sequences, a close-length table and a randomized run against a queue model.
module tb_rx_huge_page_ctrl;

    localparam int DEPTH = 4;
    localparam int PTR_W = $clog2(DEPTH);

    logic          clk156 = 1'b0;
    logic          reset_n = 1'b0;
    logic          hp_wr_en = 1'b0;
    logic [63:0]   hp_wr_addr = '0;
    logic          change_huge_page = 1'b0;
    logic [18:0]   hp_qword_count = '0;
    logic          close_ack = 1'b0;
    logic          hp_fifo_full, hp_overflow, hp_misaligned, current_hp_valid;
    logic [PTR_W:0] hp_pending;
    logic [63:0]   current_hp_addr, close_addr;
    logic          change_huge_page_ack, close_req;
    logic [18:0]   close_qwords;
    logic [31:0]   pages_closed;

    rx_huge_page_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk156(clk156), .reset_n(reset_n),
        .hp_wr_en(hp_wr_en), .hp_wr_addr(hp_wr_addr),
        .hp_fifo_full(hp_fifo_full), .hp_pending(hp_pending),
        .hp_overflow(hp_overflow), .hp_misaligned(hp_misaligned),
        .current_hp_valid(current_hp_valid), .current_hp_addr(current_hp_addr),
        .change_huge_page(change_huge_page), .change_huge_page_ack(change_huge_page_ack),
        .hp_qword_count(hp_qword_count), .close_req(close_req),
        .close_addr(close_addr), .close_qwords(close_qwords),
        .close_ack(close_ack), .pages_closed(pages_closed)
    );

    always #5 clk156 = ~clk156;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference model: a queue of waiting pages plus the lifecycle of the current one.
    logic [63:0] mq[$];
    bit          m_valid, m_creq, m_ack, m_ovf, m_mis;
    logic [63:0] m_cur, m_caddr;
    logic [18:0] m_cqw;
    logic [31:0] m_closed;

    task automatic model_reset();
        mq.delete();
        m_valid = 0; m_creq = 0; m_ack = 0; m_ovf = 0; m_mis = 0;
        m_cur = '0; m_caddr = '0; m_cqw = '0; m_closed = '0;
    endtask

    task automatic model_step();
        bit idle;
        idle = !m_valid && !m_creq && !m_ack;
        if (m_ack) begin
            if (!change_huge_page) begin
                m_ack = 0;
                idle  = 1;
            end
        end else if (m_creq) begin
            if (close_ack) begin
                m_creq = 0;
                m_ack = 1;
                m_closed = m_closed + 1;
            end
        end else if (m_valid && change_huge_page) begin
            m_valid = 0;
            m_creq  = 1;
            m_caddr = m_cur;
            m_cqw   = (hp_qword_count > 19'd16) ? hp_qword_count - 19'd16 : 19'd0;
        end
        if (idle && mq.size() > 0) begin
            m_cur   = mq.pop_front();
            m_valid = 1;
        end
        if (hp_wr_en) begin
            if (hp_wr_addr % 64'h20_0000 != 0) m_mis = 1;
            else if (mq.size() == DEPTH)       m_ovf = 1;
            else                               mq.push_back(hp_wr_addr);
        end
    endtask

    task automatic check_model();
        chk("hp_pending",   64'(hp_pending),           64'(mq.size()));
        chk("hp_fifo_full", 64'(hp_fifo_full),         64'(mq.size() == DEPTH));
        chk("hp_overflow",  64'(hp_overflow),          64'(m_ovf));
        chk("hp_misaligned",64'(hp_misaligned),        64'(m_mis));
        chk("cur_valid",    64'(current_hp_valid),     64'(m_valid));
        chk("cur_addr",     current_hp_addr,           m_cur);
        chk("chg_ack",      64'(change_huge_page_ack), 64'(m_ack));
        chk("close_req",    64'(close_req),            64'(m_creq));
        chk("close_addr",   close_addr,                m_caddr);
        chk("close_qwords", 64'(close_qwords),         64'(m_cqw));
        chk("pages_closed", 64'(pages_closed),         64'(m_closed));
    endtask

    task automatic step(input bit we, input logic [63:0] a, input bit cack);
        hp_wr_en = we; hp_wr_addr = a; close_ack = cack;
        model_step();
        @(posedge clk156); #1;
        hp_wr_en = 0; close_ack = 0;
        check_model();
    endtask

    task automatic do_reset();
        reset_n = 0; change_huge_page = 0; hp_qword_count = '0; hp_wr_en = 0; close_ack = 0;
        model_reset();
        repeat (2) @(posedge clk156);
        #1 reset_n = 1;
    endtask

    typedef struct { logic [18:0] qw; logic [18:0] exp_cqw; } qw_vec_t;
    qw_vec_t tbl[6];

    localparam logic [63:0] P0 = 64'h0000_0001_0020_0000;
    localparam logic [63:0] P1 = 64'h0000_0001_0040_0000;

    initial begin
        logic [63:0] a, page;
        tbl[0] = '{19'd16,     19'd0};
        tbl[1] = '{19'h110,    19'h100};
        tbl[2] = '{19'd5,      19'd0};
        tbl[3] = '{19'd0,      19'd0};
        tbl[4] = '{19'd17,     19'd1};
        tbl[5] = '{19'h7FFFF,  19'h7FFEF};

        do_reset();
        chk("rst valid",   64'(current_hp_valid), 64'd0);
        chk("rst pending", 64'(hp_pending),       64'd0);
        chk("rst closed",  64'(pages_closed),     64'd0);
        chk("rst creq",    64'(close_req),        64'd0);

        // Misaligned post is dropped.
        step(1, 64'h0000_0000_0010_0100, 0);
        step(0, '0, 0);
        chk("mis flag",    64'(hp_misaligned),    64'd1);
        chk("mis pending", 64'(hp_pending),       64'd0);
        chk("mis valid",   64'(current_hp_valid), 64'd0);

        // Request in NOPAGE stalls with no close.
        change_huge_page = 1;
        repeat (3) step(0, '0, 0);
        chk("stall ack",  64'(change_huge_page_ack), 64'd0);
        chk("stall creq", 64'(close_req),            64'd0);
        change_huge_page = 0;

        // First page load and pop-to-valid latency.
        step(1, P0, 0);
        chk("p0 queued",  64'(hp_pending),       64'd1);
        step(0, '0, 0);
        chk("p0 valid",   64'(current_hp_valid), 64'd1);
        chk("p0 addr",    current_hp_addr,       P0);
        chk("p0 pending", 64'(hp_pending),       64'd0);

        // Close with a second page waiting.
        step(1, P1, 0);
        hp_qword_count = 19'h110; change_huge_page = 1;
        step(0, '0, 0);
        chk("close req",  64'(close_req),    64'd1);
        chk("close addr", close_addr,        P0);
        chk("close qw",   64'(close_qwords), 64'h100);
        step(0, '0, 1);
        chk("ack set",    64'(change_huge_page_ack), 64'd1);
        chk("closed 1",   64'(pages_closed),         64'd1);
        change_huge_page = 0;
        step(0, '0, 0);
        chk("p1 addr",    current_hp_addr,   P1);
        chk("p1 pending", 64'(hp_pending),   64'd0);

        // Overflow, then a full post coinciding with the ACK-exit pop.
        for (int i = 0; i < 4; i++) step(1, 64'h0000_0003_0000_0000 + (64'(i) << 21), 0);
        chk("full",      64'(hp_fifo_full), 64'd1);
        step(1, 64'h0000_0004_0000_0000, 0);
        chk("ovf",       64'(hp_overflow),  64'd1);
        chk("ovf pend",  64'(hp_pending),   64'd4);
        change_huge_page = 1;
        step(0, '0, 0);
        step(0, '0, 1);
        change_huge_page = 0;
        step(1, 64'h0000_0005_0000_0000, 0);
        chk("swap pend", 64'(hp_pending),   64'd4);
        chk("swap full", 64'(hp_fifo_full), 64'd1);
        chk("swap cur",  current_hp_addr,   64'h0000_0003_0000_0000);
        step(0, '0, 1);
        chk("stray ack", 64'(pages_closed), 64'd2);

        // Close-length table, each row on a single page with an empty queue behind it.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            page = 64'h0000_0002_0000_0000 + (64'(i) << 21);
            step(1, page, 0);
            step(0, '0, 0);
            chk("tbl cur", current_hp_addr, page);
            hp_qword_count = tbl[i].qw; change_huge_page = 1;
            step(0, '0, 0);
            chk("tbl cqw",   64'(close_qwords), 64'(tbl[i].exp_cqw));
            chk("tbl caddr", close_addr,        page);
            step(0, '0, 1);
            change_huge_page = 0;
            step(0, '0, 0);
            chk("tbl nopage", 64'(current_hp_valid), 64'd0);
            step(0, '0, 0);
            chk("tbl idle",   64'(current_hp_valid), 64'd0);
        end

        // Reset while a close is outstanding.
        step(1, P0, 0);
        step(0, '0, 0);
        change_huge_page = 1;
        step(0, '0, 0);
        chk("pre-rst creq", 64'(close_req), 64'd1);
        #2 reset_n = 0;
        #1;
        chk("rst creq",   64'(close_req),            64'd0);
        chk("rst valid2", 64'(current_hp_valid),     64'd0);
        chk("rst closed2",64'(pages_closed),         64'd0);
        chk("rst ack",    64'(change_huge_page_ack), 64'd0);
        chk("rst caddr",  close_addr,                64'd0);
        chk("rst cur",    current_hp_addr,           64'd0);
        do_reset();
        check_model();

        // Randomized traffic with a four-phase requester.
        for (int i = 0; i < 600; i++) begin
            if (!change_huge_page && !change_huge_page_ack && $urandom_range(3) == 0)
                change_huge_page = 1;
            else if (change_huge_page && change_huge_page_ack && $urandom_range(1) == 0)
                change_huge_page = 0;
            hp_qword_count = 19'($urandom_range(600));
            a = {$urandom, $urandom};
            if ($urandom_range(7) != 0) a[20:0] = '0;
            step($urandom_range(2) == 0, a, $urandom_range(2) == 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
